// File: rtl/am_modulator_pkg.sv
// Shared types and constants for the AM modulator: the quarter-wave carrier
// table, helpers that unfold it into sin/cos, and IQ saturation.
package am_pkg;
   localparam int IQ_W    = 8;
   localparam int AUDIO_W = 16;
   localparam int ENV_MAX = 127;
   localparam int QTR_N   = 16;   // quarter-wave steps at 64 points per turn

   typedef logic signed [IQ_W-1:0] iq_t;
   typedef struct packed { iq_t c; iq_t s; } cs_t;

   // round(127*sin(k*90/16 deg)), k = 0..16; endpoints exact
   localparam iq_t QLUT [QTR_N+1] = '{
      8'sd0,   8'sd12,  8'sd25,  8'sd37,  8'sd49,  8'sd60,  8'sd71,  8'sd81,
      8'sd90,  8'sd98,  8'sd106, 8'sd112, 8'sd117, 8'sd122, 8'sd125, 8'sd126,
      8'sd127};

   function automatic iq_t lut_sin(input logic [5:0] a);
      logic [4:0] k;
      k = a[4] ? 5'(QTR_N) - {1'b0, a[3:0]} : {1'b0, a[3:0]};
      return a[5] ? -QLUT[k] : QLUT[k];
   endfunction

   function automatic cs_t lut_cs(input logic [5:0] a);
      cs_t r;
      r.c = lut_sin(a + 6'd16);
      r.s = lut_sin(a);
      return r;
   endfunction

   function automatic iq_t sat_iq(input logic signed [15:0] x);
      if (x > 16'sd127)  return 8'sd127;
      if (x < -16'sd128) return -8'sd128;
      return x[7:0];
   endfunction
endpackage

// File: rtl/am_modulator_if.sv
// Audio input stream: valid/ready handshake with a signed sample.
interface am_modulator_if;
   import am_pkg::*;
   logic signed [AUDIO_W-1:0] audio_in;
   logic                      audio_valid;
   logic                      audio_ready;

   modport master (output audio_in, audio_valid, input audio_ready);
   modport slave  (input audio_in, audio_valid, output audio_ready);
endinterface

// File: rtl/am_modulator_nco.sv
// Carrier NCO: phase accumulator advanced on en_i, registered cos/sin of the
// phase in effect before the advance.
module am_nco
   import am_pkg::*;
#(
   parameter int PHASE_W = 16,
   parameter int LUT_AW  = 6     // 2..6; narrower tables subsample the 64-point one
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en_i,
   input  logic [PHASE_W-1:0] freq_word_i,
   output cs_t                cs_o
);
   logic [PHASE_W-1:0] phase_q;
   cs_t                cs_q;
   logic [5:0]         addr;

   assign addr = 6'(phase_q[PHASE_W-1 -: LUT_AW]) << (6 - LUT_AW);
   assign cs_o = cs_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= '0;
         cs_q    <= '0;
      end else if (en_i) begin
         phase_q <= phase_q + freq_word_i;
         cs_q    <= lut_cs(addr);
      end
   end
endmodule

// File: rtl/am_modulator.sv
// Full-carrier AM modulator: one-entry audio buffer, clamped envelope,
// NCO rotation, 3-stage pipeline to signed 8-bit I/Q.
module am_modulator
   import am_pkg::*;
#(
   parameter int PHASE_W       = 16,
   parameter int LUT_AW        = 6,
   parameter int CARRIER_LEVEL = 64,
   parameter int MOD_SHIFT     = 9
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               sample_en_i,
   input  logic [PHASE_W-1:0] freq_word_i,
   am_modulator_if.slave      aud,
   output iq_t                I_out_o,
   output iq_t                Q_out_o,
   output logic               iq_valid_o,
   output logic [7:0]         underrun_cnt_o
);
   logic                      full_q, full_d, wr;
   logic signed [AUDIO_W-1:0] hold_q, hold_d, smp;
   logic [7:0]                urun_q, urun_d;
   logic signed [17:0]        env_wide;
   iq_t                       env_d, env_q, i_q, q_q;
   logic signed [15:0]        pi_q, pq_q;
   logic [2:0]                vld_pipe_q;
   cs_t                       cs;

   assign wr              = aud.audio_valid & ~full_q;
   assign aud.audio_ready = ~full_q;

   always_comb begin
      full_d = full_q;
      hold_d = hold_q;
      urun_d = urun_q;
      if (wr) hold_d = aud.audio_in;
      if (sample_en_i) begin
         full_d = 1'b0;
         if (!full_q && !wr && urun_q != 8'hFF) urun_d = urun_q + 8'd1;
      end else if (wr) begin
         full_d = 1'b1;
      end
      // Same-cycle write with an empty buffer is consumed directly.
      smp      = (full_q || !wr) ? hold_q : aud.audio_in;
      env_wide = 18'(CARRIER_LEVEL) + ($signed({{2{smp[AUDIO_W-1]}}, smp}) >>> MOD_SHIFT);
      if (env_wide < 18'sd0)             env_d = '0;
      else if (env_wide > 18'(ENV_MAX))  env_d = iq_t'(ENV_MAX);
      else                               env_d = env_wide[7:0];
   end

   am_nco #(.PHASE_W(PHASE_W), .LUT_AW(LUT_AW)) u_nco (
      .clk         (clk),
      .rst_n       (rst_n),
      .en_i        (sample_en_i),
      .freq_word_i (freq_word_i),
      .cs_o        (cs)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q     <= 1'b0;
         hold_q     <= '0;
         urun_q     <= '0;
         env_q      <= '0;
         pi_q       <= '0;
         pq_q       <= '0;
         i_q        <= '0;
         q_q        <= '0;
         vld_pipe_q <= '0;
      end else begin
         full_q     <= full_d;
         hold_q     <= hold_d;
         urun_q     <= urun_d;
         vld_pipe_q <= {vld_pipe_q[1:0], sample_en_i};
         if (sample_en_i) env_q <= env_d;
         if (vld_pipe_q[0]) begin
            pi_q <= 16'(env_q) * 16'(cs.c);
            pq_q <= 16'(env_q) * 16'(cs.s);
         end
         if (vld_pipe_q[1]) begin
            i_q <= sat_iq(pi_q >>> 7);
            q_q <= sat_iq(pq_q >>> 7);
         end
      end
   end

   assign I_out_o        = i_q;
   assign Q_out_o        = q_q;
   assign iq_valid_o     = vld_pipe_q[2];
   assign underrun_cnt_o = urun_q;
endmodule

// File: doc/am_modulator.md
Name: am_modulator

Overview:
Full-carrier AM modulator producing the 8-bit I/Q stream that the AM demodulator consumes, and serves as the loopback/stimulus source for it.
- Takes signed 16-bit audio through a one-entry valid/ready buffer.
- Forms an envelope and rotates it by an internal NCO carrier.
- Emits signed 8-bit I/Q once per sample-rate enable pulse.

Parameters:
PHASE_W, 16, NCO phase accumulator width
LUT_AW, 6, phase bits used to address the sine/cosine table (2^LUT_AW points per turn)
CARRIER_LEVEL, 64, unmodulated envelope value (0..127)
MOD_SHIFT, 9, arithmetic right shift applied to audio before adding to CARRIER_LEVEL

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sample_en  in  1  one-cycle sample-rate strobe; back-to-back pulses legal
audio_in  in  16  signed audio sample
audio_valid  in  1  audio_in valid
audio_ready  out  1  holding register empty; equals !full, no combinational path from inputs
freq_word  in  PHASE_W  NCO increment, sampled on sample_en
I_out  out  8  signed in-phase sample
Q_out  out  8  signed quadrature sample
iq_valid  out  1  one-cycle pulse, I_out/Q_out new
underrun_cnt  out  8  saturating count of sample_en pulses with no fresh audio

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - full=0, held sample=0, phase=0, all pipeline registers 0.
  - I_out=0, Q_out=0, iq_valid=0, underrun_cnt=0, audio_ready=1.
- Audio buffer:
  - A write occurs when audio_valid & audio_ready; it loads the held sample and sets full.
  - sample_en with full=1: consumes the held sample and clears full. A write in the same cycle is impossible because ready=0.
  - sample_en with full=0 and a write in the same cycle: the incoming sample bypasses the register and is consumed. full stays 0; no underrun.
  - sample_en with full=0 and no write: the last held sample is reused and underrun_cnt increments, saturating at 255.
- Envelope:
  - env = CARRIER_LEVEL + (audio >>> MOD_SHIFT), computed in 18-bit signed.
  - Clamped to 0..127.
- NCO:
  - The consumed sample uses the current phase. phase <= phase + freq_word, modulo 2^PHASE_W, on the same edge.
  - The LUT is addressed by phase[PHASE_W-1 -: LUT_AW].
  - cos/sin are signed 8-bit, amplitude 127, generated from a quarter-wave table with exact values at multiples of 90 degrees (127, 0, -127).
- Pipeline (edges counted from the sample_en cycle T):
  - E1: env, cos, sin registered.
  - E2: products env*cos and env*sin registered as 16-bit signed.
  - E3: I_out = product >>> 7 (floor), saturated to -128..127; Q_out likewise; iq_valid=1 for exactly one cycle.
  - Latency is 3 clocks.
  - Fully pipelined: one result per sample_en.
- I_out/Q_out hold their value between iq_valid pulses.
- freq_word changes apply only at the next sample_en.
- Reset mid-operation flushes the pipeline; no iq_valid pulse may emerge from pre-reset samples.

Decomposition:
- Package am_pkg holds:
  - IQ_W=8, AUDIO_W=16, ENV_MAX=127;
  - the quarter-wave LUT constant and its generation function;
  - signed saturate helper function.
- One sub-module, am_nco: phase accumulator plus LUT with registered cos/sin outputs, advanced by an enable input. Its registered output is pipeline stage E1.
- Top level: buffer, envelope, multiply, saturate, counters.

Test Plan:
- Unmodulated carrier: reset, no audio, freq_word=0, sample_en every 4 clocks -> every iq_valid gives I=63, Q=0; underrun_cnt counts 1,2,3...
- Quarter-turn rotation: freq_word=16384, audio=0 written before each sample_en -> (I,Q) sequence (63,0),(0,63),(-64,0),(0,-64), repeating; underrun_cnt stays 0.
- Envelope clamp: freq_word=0, audio=+32767 -> I=126, Q=0; audio=-32768 -> I=0, Q=0.
- Handshake corners:
  - audio_valid held high with sample_en every 3 clocks -> audio_ready low while full, each sample consumed exactly once.
  - Write and sample_en in the same cycle with full=0 -> bypass value appears at E3, no underrun.
- Latency and back-to-back: sample_en high 4 consecutive cycles -> iq_valid high for 4 consecutive cycles starting 3 clocks later.
- Reset mid-pipeline: assert rst_n=0 one clock after sample_en -> outputs go to 0 immediately, no iq_valid afterwards, phase restarts at 0.
